// File: rtl/sipo_frame_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : sipo_frame_rx_if
// Description : Serial input strobe, output handshake and status bundle
//               for the SIPO frame receiver.
// Revision    : 1.0  initial release
// ============================================================================
interface sipo_frame_rx_if #(
    parameter int WIDTH = 4
);
    logic             shift_en;
    logic             si;
    logic             ready;
    logic             ovr_clr;
    logic [WIDTH-1:0] data_out;
    logic             valid;
    logic             busy;
    logic             overrun;

    modport master (
        output shift_en, si, ready, ovr_clr,
        input  data_out, valid, busy, overrun
    );

    modport slave (
        input  shift_en, si, ready, ovr_clr,
        output data_out, valid, busy, overrun
    );
endinterface
`default_nettype wire

// File: rtl/sipo_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : sipo_frame_rx
// Description : Start-bit framed serial-in parallel-out receiver with a
//               registered valid/ready output buffer and sticky overrun flag.
// Revision    : 1.0  initial release
// ============================================================================
module sipo_frame_rx #(
    parameter int WIDTH = 4,
    parameter int CW    = 3
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    sipo_frame_rx_if.slave   bus
);
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    state_t             r_state;
    logic [CW-1:0]      r_count;
    logic [WIDTH-2:0]   r_shreg;
    logic [WIDTH-1:0]   r_data;
    logic               r_valid;
    logic               r_busy;
    logic               r_overrun;
    logic [WIDTH-1:0]   w_word;

    // Only the bits collected so far are stored; the final bit joins straight from si.
    assign w_word = {r_shreg, bus.si};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_shreg   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (r_valid && bus.ready) begin
                r_valid <= 1'b0;
            end
            if (bus.ovr_clr) begin
                r_overrun <= 1'b0;
            end
            if (bus.shift_en) begin
                case (r_state)
                    IDLE: begin
                        if (bus.si) begin
                            r_state <= SHIFT;
                            r_busy  <= 1'b1;
                            r_count <= '0;
                        end
                    end
                    SHIFT: begin
                        r_shreg <= w_word[WIDTH-2:0];
                        if (r_count == C_LAST) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_count <= '0;
                            // A completing word overrides the transfer-clear and any overrun clear.
                            if (!r_valid || bus.ready) begin
                                r_data  <= w_word;
                                r_valid <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_count <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.data_out = r_data;
    assign bus.valid    = r_valid;
    assign bus.busy     = r_busy;
    assign bus.overrun  = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_sipo_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_sipo_frame_rx
// Description : Directed and random bench for sipo_frame_rx with a frame-level
//               reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sipo_frame_rx;
    localparam int WIDTH = 4;
    localparam int CW    = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passes = 0;

    sipo_frame_rx_if #(.WIDTH(WIDTH)) bus ();

    sipo_frame_rx #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: collects frame bits as an integer value.
    bit m_in_frame;
    int m_nbits;
    int m_acc;
    bit m_valid;
    int m_data;
    bit m_ovr;

    task automatic model_reset();
        m_in_frame = 0; m_nbits = 0; m_acc = 0;
        m_valid = 0; m_data = 0; m_ovr = 0;
    endtask

    task automatic model_step();
        bit nv;
        bit novr;
        nv   = m_valid && !bus.ready;
        novr = m_ovr && !bus.ovr_clr;
        if (bus.shift_en) begin
            if (!m_in_frame) begin
                if (bus.si) begin
                    m_in_frame = 1; m_nbits = 0; m_acc = 0;
                end
            end else begin
                m_acc   = m_acc * 2 + int'(bus.si);
                m_nbits = m_nbits + 1;
                if (m_nbits == WIDTH) begin
                    m_in_frame = 0;
                    if (!m_valid || bus.ready) begin
                        m_data = m_acc;
                        nv = 1;
                    end else begin
                        novr = 1;
                    end
                end
            end
        end
        m_valid = nv;
        m_ovr   = novr;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_model(input string tag);
        check({tag, ".valid"},   32'(bus.valid),    32'(m_valid));
        check({tag, ".data"},    32'(bus.data_out), 32'(m_data));
        check({tag, ".busy"},    32'(bus.busy),     32'(m_in_frame));
        check({tag, ".overrun"}, 32'(bus.overrun),  32'(m_ovr));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus.shift_en = 1'b1;
        bus.si       = b;
        tick();
    endtask

    // Start bit plus WIDTH data bits MSB first; ready is raised only on the last bit.
    task automatic send_frame(input logic [WIDTH-1:0] val, input logic last_ready);
        bus.ready = 1'b0;
        send_bit(1'b1);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i == 0) bus.ready = last_ready;
            send_bit(val[i]);
        end
        bus.ready = 1'b0;
    endtask

    initial begin
        bus.shift_en = 1'b0;
        bus.si       = 1'b0;
        bus.ready    = 1'b0;
        bus.ovr_clr  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: idle fill
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        check("t1.valid", 32'(bus.valid), 32'd0);
        check("t1.busy", 32'(bus.busy), 32'd0);
        check("t1.overrun", 32'(bus.overrun), 32'd0);
        check("t1.data", 32'(bus.data_out), 32'd0);

        // 2: frame 1011 with ready held high
        bus.ready = 1'b1;
        send_bit(1'b1);
        check("t2.busy1", 32'(bus.busy), 32'd1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        check("t2.busy4", 32'(bus.busy), 32'd1);
        check("t2.valid_early", 32'(bus.valid), 32'd0);
        send_bit(1'b1);
        check("t2.valid", 32'(bus.valid), 32'd1);
        check("t2.data", 32'(bus.data_out), 32'hB);
        check("t2.busy_done", 32'(bus.busy), 32'd0);
        send_bit(1'b0);
        check("t2.valid_one_cycle", 32'(bus.valid), 32'd0);
        check_model("t2");

        // 3: overrun on back-to-back frames, then drain and clear
        send_frame(4'hA, 1'b0);
        send_frame(4'h5, 1'b0);
        check("t3.data", 32'(bus.data_out), 32'hA);
        check("t3.overrun", 32'(bus.overrun), 32'd1);
        check("t3.valid", 32'(bus.valid), 32'd1);
        bus.si = 1'b0; bus.ready = 1'b1; tick(); bus.ready = 1'b0;
        check("t3.drained", 32'(bus.valid), 32'd0);
        check("t3.overrun_sticky", 32'(bus.overrun), 32'd1);
        bus.ovr_clr = 1'b1; tick(); bus.ovr_clr = 1'b0;
        check("t3.ovr_clr", 32'(bus.overrun), 32'd0);
        check_model("t3");

        // 4: transfer coincides with next word load
        send_frame(4'h3, 1'b0);
        check("t4.data3", 32'(bus.data_out), 32'h3);
        send_frame(4'hC, 1'b1);
        check("t4.valid", 32'(bus.valid), 32'd1);
        check("t4.data", 32'(bus.data_out), 32'hC);
        check("t4.overrun", 32'(bus.overrun), 32'd0);
        bus.si = 1'b0; bus.ready = 1'b1; tick(); bus.ready = 1'b0;
        check_model("t4");

        // 5: gapped strobe
        begin
            logic [4:0] bits;
            bits = 5'b11001;
            for (int i = 4; i >= 0; i--) begin
                bus.shift_en = 1'b1; bus.si = bits[i]; tick();
                if (i == 0) begin
                    check("t5.valid", 32'(bus.valid), 32'd1);
                    check("t5.data", 32'(bus.data_out), 32'h9);
                end else begin
                    check("t5.valid_early", 32'(bus.valid), 32'd0);
                end
                bus.shift_en = 1'b0; bus.si = ~bus.si; tick();
            end
        end
        check("t5.hold", 32'(bus.data_out), 32'h9);
        bus.ready = 1'b1; tick(); bus.ready = 1'b0;
        check_model("t5");

        // 6: async reset mid-frame
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        check("t6.busy_before", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("t6.valid", 32'(bus.valid), 32'd0);
        check("t6.busy", 32'(bus.busy), 32'd0);
        check("t6.overrun", 32'(bus.overrun), 32'd0);
        check("t6.data", 32'(bus.data_out), 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        send_frame(4'h6, 1'b0);
        check("t6.frame", 32'(bus.data_out), 32'h6);
        check("t6.valid_after", 32'(bus.valid), 32'd1);
        check_model("t6");

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            bus.shift_en = ($urandom_range(0, 3) != 0);
            bus.si       = ($urandom_range(0, 1) == 1);
            bus.ready    = ($urandom_range(0, 3) == 0);
            bus.ovr_clr  = ($urandom_range(0, 15) == 0);
            tick();
            check_model("rand");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
